// File: rtl/gtp_rx_word_filter.sv
// ----------------------------------------------------------------------------
// gtp_rx_word_filter
//
// Receive-side stage between the GTP RX user interface and the RX FIFO write
// port. Each cycle the incoming decoded word is classified as IDLE, DATA or
// BAD. A run of LOCK_CNT consecutive IDLE words brings the link up. While the
// link is up, DATA words are pushed into the FIFO and IDLE words are stripped.
// A run of ERR_LIMIT consecutive BAD words drops the link back to hunting.
//
// Ports:
//   gtp_clk       RX user clock; all state changes on its rising edge
//   reset         synchronous, active-high
//   rxinit_done   transceiver RX init complete; low forces WAIT_INIT
//   rxdata        decoded 16-bit RX word
//   rxcharisk     per-byte K flag (bit0 -> rxdata[7:0])
//   rxdisperr     per-byte disparity error
//   rxnotintable  per-byte not-in-table error
//   fifo_full     RX FIFO full, sampled with the DATA word it gates
//   fifo_din      word to FIFO (holds the last written word)
//   fifo_wr_en    one-cycle write strobe per accepted DATA word
//   link_up       high while LOCKED
//   err_count     saturating count of BAD words seen while LOCKED (sticky)
//   overflow      sticky flag: a DATA word was dropped because of fifo_full
// ----------------------------------------------------------------------------
module gtp_rx_word_filter #(
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned ERR_LIMIT = 3,
    parameter logic [15:0] IDLE_WORD = 16'h50BC,
    parameter logic [1:0]  IDLE_K    = 2'b01
) (
    input  logic        gtp_clk,
    input  logic        reset,
    input  logic        rxinit_done,
    input  logic [15:0] rxdata,
    input  logic [1:0]  rxcharisk,
    input  logic [1:0]  rxdisperr,
    input  logic [1:0]  rxnotintable,
    input  logic        fifo_full,
    output logic [15:0] fifo_din,
    output logic        fifo_wr_en,
    output logic        link_up,
    output logic [7:0]  err_count,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_HUNT      = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_DATA = 2'd0,
        CLS_IDLE = 2'd1,
        CLS_BAD  = 2'd2
    } word_class_t;

    // Terminal counter values: the transition fires when the last word of a
    // run is sampled while the counter already holds LIMIT-1.
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0] ERR_LAST  = 4'(ERR_LIMIT - 1);

    // Any decode error wins; a K flag pattern other than plain data or the
    // exact IDLE ordered set is treated as corruption.
    function automatic word_class_t classify_word(
        input logic [15:0] data,
        input logic [1:0]  charisk,
        input logic [1:0]  disperr,
        input logic [1:0]  notintable
    );
        word_class_t cls;
        if ((disperr != 2'b00) || (notintable != 2'b00)) begin
            cls = CLS_BAD;
        end else if (charisk == 2'b00) begin
            cls = CLS_DATA;
        end else if ((charisk == IDLE_K) && (data == IDLE_WORD)) begin
            cls = CLS_IDLE;
        end else begin
            cls = CLS_BAD;
        end
        return cls;
    endfunction

    state_t      state_r,     state_nxt_s;
    logic [3:0]  lock_cnt_r,  lock_cnt_nxt_s;
    logic [3:0]  err_run_r,   err_run_nxt_s;
    logic [15:0] fifo_din_r,  fifo_din_nxt_s;
    logic        fifo_wr_en_r, fifo_wr_en_nxt_s;
    logic        link_up_r;
    logic [7:0]  err_count_r, err_count_nxt_s;
    logic        overflow_r,  overflow_nxt_s;
    word_class_t cls_s;

    assign cls_s = classify_word(rxdata, rxcharisk, rxdisperr, rxnotintable);

    assign fifo_din   = fifo_din_r;
    assign fifo_wr_en = fifo_wr_en_r;
    assign link_up    = link_up_r;
    assign err_count  = err_count_r;
    assign overflow   = overflow_r;

    // Next-state, counter and output-register logic for the lock FSM.
    always_comb begin
        state_nxt_s      = state_r;
        lock_cnt_nxt_s   = lock_cnt_r;
        err_run_nxt_s    = err_run_r;
        fifo_din_nxt_s   = fifo_din_r;
        fifo_wr_en_nxt_s = 1'b0;
        err_count_nxt_s  = err_count_r;
        overflow_nxt_s   = overflow_r;

        if (!rxinit_done) begin
            // Loss of init overrides everything; the sticky flags are kept.
            state_nxt_s = ST_WAIT_INIT;
        end else begin
            case (state_r)
                ST_WAIT_INIT: begin
                    state_nxt_s    = ST_HUNT;
                    lock_cnt_nxt_s = 4'd0;
                end
                ST_HUNT: begin
                    case (cls_s)
                        CLS_IDLE: begin
                            if (lock_cnt_r == LOCK_LAST) begin
                                state_nxt_s   = ST_LOCKED;
                                err_run_nxt_s = 4'd0;
                            end else begin
                                lock_cnt_nxt_s = lock_cnt_r + 4'd1;
                            end
                        end
                        default: begin
                            lock_cnt_nxt_s = 4'd0;
                        end
                    endcase
                end
                ST_LOCKED: begin
                    case (cls_s)
                        CLS_DATA: begin
                            err_run_nxt_s = 4'd0;
                            if (fifo_full) begin
                                overflow_nxt_s = 1'b1;
                            end else begin
                                fifo_wr_en_nxt_s = 1'b1;
                                fifo_din_nxt_s   = rxdata;
                            end
                        end
                        CLS_IDLE: begin
                            err_run_nxt_s = 4'd0;
                        end
                        CLS_BAD: begin
                            if (err_count_r != 8'hFF) begin
                                err_count_nxt_s = err_count_r + 8'd1;
                            end else begin
                                err_count_nxt_s = err_count_r;
                            end
                            if (err_run_r == ERR_LAST) begin
                                state_nxt_s    = ST_HUNT;
                                lock_cnt_nxt_s = 4'd0;
                            end else begin
                                err_run_nxt_s = err_run_r + 4'd1;
                            end
                        end
                        default: begin
                            err_run_nxt_s = err_run_r;
                        end
                    endcase
                end
                default: begin
                    state_nxt_s = ST_WAIT_INIT;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset also kills a pending strobe.
    always_ff @(posedge gtp_clk) begin
        if (reset) begin
            state_r      <= ST_WAIT_INIT;
            lock_cnt_r   <= 4'd0;
            err_run_r    <= 4'd0;
            fifo_din_r   <= 16'd0;
            fifo_wr_en_r <= 1'b0;
            link_up_r    <= 1'b0;
            err_count_r  <= 8'd0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            lock_cnt_r   <= lock_cnt_nxt_s;
            err_run_r    <= err_run_nxt_s;
            fifo_din_r   <= fifo_din_nxt_s;
            fifo_wr_en_r <= fifo_wr_en_nxt_s;
            link_up_r    <= (state_nxt_s == ST_LOCKED);
            err_count_r  <= err_count_nxt_s;
            overflow_r   <= overflow_nxt_s;
        end
    end

endmodule

// File: tb/tb_gtp_rx_word_filter.sv
// ----------------------------------------------------------------------------
// Testbench for gtp_rx_word_filter: a table of hand-derived vectors for the
// bring-up/write/overflow path, hand-written multi-cycle sequences for error
// handling, init drop, relock, saturation and mid-stream reset, then random
// traffic compared against a behavioural model of the link rules.
// ----------------------------------------------------------------------------
module tb_gtp_rx_word_filter;

    localparam int          LOCK_CNT  = 4;
    localparam int          ERR_LIMIT = 3;
    localparam logic [15:0] IW        = 16'h50BC;
    localparam logic [1:0]  IK        = 2'b01;

    logic        gtp_clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxinit_done = 1'b0;
    logic [15:0] rxdata = 16'd0;
    logic [1:0]  rxcharisk = 2'b00;
    logic [1:0]  rxdisperr = 2'b00;
    logic [1:0]  rxnotintable = 2'b00;
    logic        fifo_full = 1'b0;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        link_up;
    logic [7:0]  err_count;
    logic        overflow;

    always #5 gtp_clk = ~gtp_clk;

    gtp_rx_word_filter #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_LIMIT(ERR_LIMIT),
        .IDLE_WORD(IW),
        .IDLE_K   (IK)
    ) dut (
        .gtp_clk     (gtp_clk),
        .reset       (reset),
        .rxinit_done (rxinit_done),
        .rxdata      (rxdata),
        .rxcharisk   (rxcharisk),
        .rxdisperr   (rxdisperr),
        .rxnotintable(rxnotintable),
        .fifo_full   (fifo_full),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .link_up     (link_up),
        .err_count   (err_count),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: is the receiver up, is the link locked, how long the
    // current run of IDLEs / BADs is, plus the visible outputs.
    bit          m_active = 1'b0;
    bit          m_locked = 1'b0;
    int          m_idle_run = 0;
    int          m_bad_run = 0;
    logic        m_wr = 1'b0;
    logic [15:0] m_din = 16'd0;
    int          m_errs = 0;
    logic        m_ovf = 1'b0;

    // 0 = DATA, 1 = IDLE, 2 = BAD
    function automatic int word_kind(input logic [15:0] d, input logic [1:0] k,
                                     input logic [1:0] de, input logic [1:0] nit);
        if (de != 2'b00 || nit != 2'b00) return 2;
        if (k == 2'b00) return 0;
        if (k == IK && d == IW) return 1;
        return 2;
    endfunction

    task automatic model_step();
        int kind;
        kind = word_kind(rxdata, rxcharisk, rxdisperr, rxnotintable);
        m_wr = 1'b0;
        if (reset) begin
            m_active = 1'b0; m_locked = 1'b0; m_idle_run = 0; m_bad_run = 0;
            m_din = 16'd0; m_errs = 0; m_ovf = 1'b0;
        end else if (!rxinit_done) begin
            m_active = 1'b0;
            m_locked = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_idle_run = 0;
        end else if (!m_locked) begin
            if (kind == 1) begin
                m_idle_run++;
                if (m_idle_run == LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_bad_run = 0;
                end
            end else begin
                m_idle_run = 0;
            end
        end else begin
            if (kind == 2) begin
                if (m_errs < 255) m_errs++;
                m_bad_run++;
                if (m_bad_run == ERR_LIMIT) begin
                    m_locked = 1'b0;
                    m_idle_run = 0;
                end
            end else begin
                m_bad_run = 0;
                if (kind == 0) begin
                    if (fifo_full) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_wr = 1'b1;
                        m_din = rxdata;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_wr"},   32'(fifo_wr_en), 32'(m_wr));
        check({tag, "_din"},  32'(fifo_din),   32'(m_din));
        check({tag, "_link"}, 32'(link_up),    32'(m_locked));
        check({tag, "_err"},  32'(err_count),  32'(m_errs));
        check({tag, "_ovf"},  32'(overflow),   32'(m_ovf));
    endtask

    // Apply one word, clock it in, advance the model, sample 1 ns later.
    task automatic drive(input logic rst, input logic init, input logic [15:0] d,
                         input logic [1:0] k, input logic [1:0] de,
                         input logic [1:0] nit, input logic full);
        reset = rst; rxinit_done = init; rxdata = d; rxcharisk = k;
        rxdisperr = de; rxnotintable = nit; fifo_full = full;
        @(posedge gtp_clk);
        model_step();
        #1;
    endtask

    task automatic idle_w(input string tag);
        drive(1'b0, 1'b1, IW, IK, 2'b00, 2'b00, 1'b0);
        check_model(tag);
    endtask

    task automatic data_w(input string tag, input logic [15:0] d);
        drive(1'b0, 1'b1, d, 2'b00, 2'b00, 2'b00, 1'b0);
        check_model(tag);
    endtask

    task automatic bad_w(input string tag);
        drive(1'b0, 1'b1, 16'h1234, 2'b00, 2'b01, 2'b00, 1'b0);
        check_model(tag);
    endtask

    typedef struct {
        logic        rst;
        logic        init;
        logic [15:0] d;
        logic [1:0]  k;
        logic [1:0]  de;
        logic [1:0]  nit;
        logic        full;
        logic        e_wr;
        logic [15:0] e_din;
        logic        e_link;
        logic [7:0]  e_err;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Reset with init low, init raised, 3 IDLE (no lock), 4th IDLE (lock),
        // writes with an IDLE gap, overflow on full, write after full clears.
        vecs[0]  = '{1'b1, 1'b0, 16'h1234, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, IW,       IK,    2'b00, 2'b00, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 16'hABCD, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h1111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, IW,       IK,    2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, IW,       IK,    2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, IW,       IK,    2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, IW,       IK,    2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 8'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h1234, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 16'h1234, 1'b1, 8'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'hABCD, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 16'hABCD, 1'b1, 8'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, IW,       IK,    2'b00, 2'b00, 1'b0, 1'b0, 16'hABCD, 1'b1, 8'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 16'h0001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0001, 1'b1, 8'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'h5555, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0001, 1'b1, 8'd0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, IW,       IK,    2'b00, 2'b00, 1'b0, 1'b0, 16'h0001, 1'b1, 8'd0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 16'h6666, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 16'h6666, 1'b1, 8'd0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].init, vecs[i].d, vecs[i].k, vecs[i].de,
                  vecs[i].nit, vecs[i].full);
            check($sformatf("vec%0d_wr", i),   32'(fifo_wr_en), 32'(vecs[i].e_wr));
            check($sformatf("vec%0d_din", i),  32'(fifo_din),   32'(vecs[i].e_din));
            check($sformatf("vec%0d_link", i), 32'(link_up),    32'(vecs[i].e_link));
            check($sformatf("vec%0d_err", i),  32'(err_count),  32'(vecs[i].e_err));
            check($sformatf("vec%0d_ovf", i),  32'(overflow),   32'(vecs[i].e_ovf));
        end

        // Two BAD, an IDLE that breaks the run, then three BAD drop the link.
        bad_w("s4_b1");
        bad_w("s4_b2");
        idle_w("s4_i");
        bad_w("s4_b3");
        bad_w("s4_b4");
        check("s4_link_before_last_bad", 32'(link_up), 32'd1);
        bad_w("s4_b5");
        check("s4_err_count", 32'(err_count), 32'd5);
        check("s4_link_dropped", 32'(link_up), 32'd0);
        data_w("s4_unlocked_data", 16'h7777);
        check("s4_no_write_unlocked", 32'(fifo_wr_en), 32'd0);
        for (int i = 0; i < 4; i++) idle_w("s4_relock");
        check("s4_relocked", 32'(link_up), 32'd1);
        data_w("s4_data_after_relock", 16'h8888);
        check("s4_write_after_relock", 32'(fifo_din), 32'h8888);

        // rxinit_done drops for one cycle while DATA arrives.
        drive(1'b0, 1'b0, 16'h9999, 2'b00, 2'b00, 2'b00, 1'b0);
        check_model("s5_drop");
        check("s5_no_write", 32'(fifo_wr_en), 32'd0);
        check("s5_link_down", 32'(link_up), 32'd0);
        check("s5_err_kept", 32'(err_count), 32'd5);
        check("s5_ovf_kept", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++) idle_w("s5_relock");
        check("s5_relocked", 32'(link_up), 32'd1);

        // In HUNT, a DATA word restarts the IDLE run.
        drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
        check_model("s6_down");
        data_w("s6_enter_hunt", 16'h0F0F);
        idle_w("s6_i1");
        idle_w("s6_i2");
        data_w("s6_break", 16'h4242);
        check("s6_hunt_no_write", 32'(fifo_wr_en), 32'd0);
        for (int i = 0; i < 3; i++) idle_w("s6_run");
        check("s6_not_yet_locked", 32'(link_up), 32'd0);
        idle_w("s6_run4");
        check("s6_locked", 32'(link_up), 32'd1);
        // K28.5 with the wrong second byte is BAD.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'h00BC, IK, 2'b00, 2'b00, 1'b0);
            check_model("s6_bad_k");
        end
        check("s6_bad_k_errs", 32'(err_count), 32'd8);
        check("s6_bad_k_unlock", 32'(link_up), 32'd0);

        // err_count saturation: relock, then BAD,BAD,IDLE keeps lock and counts.
        for (int i = 0; i < 4; i++) idle_w("sat_lock");
        for (int i = 0; i < 130; i++) begin
            bad_w("sat_b");
            bad_w("sat_b");
            idle_w("sat_i");
        end
        check("sat_err_count", 32'(err_count), 32'd255);

        // Reset while a write strobe is pending.
        data_w("rst_pre", 16'h1357);
        check("rst_pre_wr", 32'(fifo_wr_en), 32'd1);
        drive(1'b1, 1'b1, 16'h2468, 2'b00, 2'b00, 2'b00, 1'b0);
        check_model("rst_mid");
        check("rst_mid_wr", 32'(fifo_wr_en), 32'd0);
        check("rst_mid_din", 32'(fifo_din), 32'd0);
        check("rst_mid_err", 32'(err_count), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic        r_init;
            logic [15:0] r_d;
            logic [1:0]  r_k;
            logic [1:0]  r_de;
            logic [1:0]  r_nit;
            logic        r_full;
            int          sel;
            r_rst  = ($urandom_range(0, 499) == 0);
            r_init = ($urandom_range(0, 63) != 0);
            r_full = ($urandom_range(0, 7) == 0);
            r_d    = 16'($urandom);
            r_k    = 2'b00;
            r_de   = 2'b00;
            r_nit  = 2'b00;
            sel    = $urandom_range(0, 99);
            if (sel < 50) begin
                r_d = IW;
                r_k = IK;
            end else if (sel < 85) begin
                r_k = 2'b00;
            end else begin
                case ($urandom_range(0, 3))
                    0: r_de  = 2'($urandom_range(1, 3));
                    1: r_nit = 2'($urandom_range(1, 3));
                    2: r_k   = 2'($urandom_range(2, 3));
                    default: begin
                        r_k = IK;
                        if (r_d == IW) r_d = r_d ^ 16'h0100;
                    end
                endcase
            end
            drive(r_rst, r_init, r_d, r_k, r_de, r_nit, r_full);
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
